risc_datapath: RTL and testbench

// 32-bit single-bus datapath of the RISC CPU: register file, PC, MAR/MDR, Y, 64-bit Z, HI/LO and ALU.
// It is driven cycle-by-cycle by control strobes from the control unit or a bench.
// One shared 32-bit bus carries data between registers.

---
 rtl/risc_pkg.sv | 35 +++
 rtl/alu.sv | 63 ++++++
 rtl/bus_mux.sv | 23 ++
 rtl/reg32.sv | 20 ++
 rtl/risc_datapath.sv | 79 +++++++
 tb/tb_risc_datapath.sv | 248 ++++++++++++++++++++++++
 6 files changed

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared widths, ALU opcodes and bus source indices for the RISC datapath
package risc_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;
    localparam int NSRC  = NREGS + 7;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Index of each bus source in the request/source vectors; lower index wins.
    typedef enum logic [4:0] {
        SEL_R0     = 5'd0,
        SEL_HI     = 5'd16,
        SEL_LO     = 5'd17,
        SEL_ZHIGH  = 5'd18,
        SEL_ZLOW   = 5'd19,
        SEL_PC     = 5'd20,
        SEL_MDR    = 5'd21,
        SEL_INPORT = 5'd22,
        SEL_NONE   = 5'd23
    } bus_sel_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU with 64-bit result for mul/div, A from Y and B from the bus
module alu
    import risc_pkg::*;
(
    input  logic [4:0]         opcode,
    input  logic               inc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    logic [4:0]         shamt;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign shamt   = b[4:0];
    assign product = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

    // Divide by zero yields all-ones quotient and passes the dividend through as remainder.
    always_comb begin
        if (b == '0) begin
            quot = '1;
            rem  = a;
        end else begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        result = '0;
        dbl    = '0;
        if (inc) begin
            result[WIDTH-1:0] = b + WIDTH'(1);
        end else begin
            case (opcode)
                OP_ADD:  result[WIDTH-1:0] = a + b;
                OP_SUB:  result[WIDTH-1:0] = a - b;
                OP_AND:  result[WIDTH-1:0] = a & b;
                OP_OR:   result[WIDTH-1:0] = a | b;
                OP_SHR:  result[WIDTH-1:0] = a >> shamt;
                OP_SHRA: result[WIDTH-1:0] = $signed(a) >>> shamt;
                OP_SHL:  result[WIDTH-1:0] = a << shamt;
                OP_ROR: begin
                    dbl               = {a, a} >> shamt;
                    result[WIDTH-1:0] = dbl[WIDTH-1:0];
                end
                OP_ROL: begin
                    dbl               = {a, a} << shamt;
                    result[WIDTH-1:0] = dbl[2*WIDTH-1:WIDTH];
                end
                OP_MUL:  result = product;
                OP_DIV:  result = {rem, quot};
                OP_NEG:  result[WIDTH-1:0] = -b;
                OP_NOT:  result[WIDTH-1:0] = ~b;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/bus_mux.sv
// rtl/bus_mux.sv - fixed-priority source selection and mux for the shared datapath bus
module bus_mux
    import risc_pkg::*;
(
    input  logic [NSRC-1:0]            req,
    input  logic [NSRC-1:0][WIDTH-1:0] src,
    output logic [WIDTH-1:0]           bus
);

    logic [4:0] sel;

    always_comb begin
        sel = SEL_NONE;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (req[k]) begin
                sel = k[4:0];
            end
        end
    end

    assign bus = (sel == SEL_NONE) ? '0 : src[sel];

endmodule

// File: rtl/reg32.sv
// rtl/reg32.sv - 32-bit load-enable register with asynchronous active-low clear
module reg32
    import risc_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/risc_datapath.sv
// rtl/risc_datapath.sv - single-bus 32-bit RISC datapath driven by external control strobes
module risc_datapath
    import risc_pkg::*;
(
    input  logic             Clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             Read,
    input  logic             IncPC,
    input  logic [NREGS-1:0] Rin,
    input  logic [NREGS-1:0] Rout,
    input  logic             PCin,
    input  logic             Zin,
    input  logic             MDRin,
    input  logic             MARin,
    input  logic             Yin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             PCout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             MDRout,
    input  logic             InPortout,
    input  logic [4:0]       opcode,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] mar
);

    logic [NREGS-1:0][WIDTH-1:0] r;
    logic [WIDTH-1:0]            pc;
    logic [WIDTH-1:0]            mdr;
    logic [WIDTH-1:0]            y;
    logic [WIDTH-1:0]            hi;
    logic [WIDTH-1:0]            lo;
    logic [2*WIDTH-1:0]          z;
    logic [2*WIDTH-1:0]          alu_result;
    logic [NSRC-1:0]             req;
    logic [NSRC-1:0][WIDTH-1:0]  src;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        reg32 u_r (.clk(Clock), .clear(clear), .en(Rin[i]), .d(bus), .q(r[i]));
    end

    reg32 u_pc  (.clk(Clock), .clear(clear), .en(PCin),  .d(bus), .q(pc));
    reg32 u_mar (.clk(Clock), .clear(clear), .en(MARin), .d(bus), .q(mar));
    reg32 u_y   (.clk(Clock), .clear(clear), .en(Yin),   .d(bus), .q(y));
    reg32 u_hi  (.clk(Clock), .clear(clear), .en(HIin),  .d(bus), .q(hi));
    reg32 u_lo  (.clk(Clock), .clear(clear), .en(LOin),  .d(bus), .q(lo));
    reg32 u_mdr (.clk(Clock), .clear(clear), .en(MDRin), .d(Read ? Mdatain : bus), .q(mdr));

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            z <= '0;
        end else if (Zin) begin
            z <= alu_result;
        end
    end

    alu u_alu (
        .opcode (opcode),
        .inc    (IncPC),
        .a      (y),
        .b      (bus),
        .result (alu_result)
    );

    // Packing order matches bus_sel_e so the request bit index is the source index.
    assign req = {InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout};
    assign src = {Mdatain, mdr, pc, z[WIDTH-1:0], z[2*WIDTH-1:WIDTH], lo, hi, r};

    bus_mux u_bus (
        .req (req),
        .src (src),
        .bus (bus)
    );

endmodule

// File: tb/tb_risc_datapath.sv
// tb/tb_risc_datapath.sv - directed scoreboard bench for risc_datapath
module tb_risc_datapath;
    import risc_pkg::*;

    localparam int D_HI  = 16;
    localparam int D_LO  = 17;
    localparam int D_PC  = 20;
    localparam int D_Y   = 24;
    localparam int D_MAR = 25;
    localparam int S_ZH  = 18;
    localparam int S_ZL  = 19;

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] Mdatain = '0;
    logic        Read = 1'b0, IncPC = 1'b0;
    logic [15:0] Rin = '0, Rout = '0;
    logic        PCin = 1'b0, Zin = 1'b0, MDRin = 1'b0, MARin = 1'b0, Yin = 1'b0, HIin = 1'b0, LOin = 1'b0;
    logic        PCout = 1'b0, Zhighout = 1'b0, Zlowout = 1'b0, HIout = 1'b0, LOout = 1'b0;
    logic        MDRout = 1'b0, InPortout = 1'b0;
    logic [4:0]  opcode = '0;
    logic [31:0] bus, mar;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 Clock = ~Clock;

    risc_datapath dut (
        .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout),
        .InPortout(InPortout), .opcode(opcode), .bus(bus), .mar(mar)
    );

    task automatic idle();
        Read = 0; IncPC = 0; Rin = '0; Rout = '0; PCin = 0; Zin = 0; MDRin = 0; MARin = 0;
        Yin = 0; HIin = 0; LOin = 0; PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0;
        LOout = 0; MDRout = 0; InPortout = 0; opcode = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic drive_src(input int k, input logic on);
        case (k)
            16: HIout = on;
            17: LOout = on;
            18: Zhighout = on;
            19: Zlowout = on;
            20: PCout = on;
            21: MDRout = on;
            22: InPortout = on;
            default: Rout[k] = on;
        endcase
    endtask

    task automatic drive_dst(input int k, input logic on);
        case (k)
            D_HI:  HIin = on;
            D_LO:  LOin = on;
            D_PC:  PCin = on;
            D_Y:   Yin = on;
            D_MAR: MARin = on;
            default: Rin[k] = on;
        endcase
    endtask

    task automatic read_src(input int k);
        @(negedge Clock);
        drive_src(k, 1'b1);
        #1;
        compare(bus);
        drive_src(k, 1'b0);
    endtask

    task automatic load(input logic [31:0] v, input int dst);
        Mdatain = v; Read = 1; MDRin = 1;
        tick(); idle();
        MDRout = 1; drive_dst(dst, 1'b1);
        tick(); idle();
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        load(a, D_Y);
        Mdatain = b; InPortout = 1; opcode = op; Zin = 1;
        tick(); idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #12 clear = 1'b1;
        tick();

        // Populate every register before the mid-run reset.
        for (int i = 0; i < 16; i++) load(32'h100 + 32'(i), i);
        load(32'hAB, D_HI);
        load(32'hCD, D_LO);
        load(32'h77, D_PC);
        load(32'h10, D_Y);
        load(32'h66, D_MAR);
        Mdatain = 32'h3; InPortout = 1; opcode = OP_ADD; Zin = 1;
        tick(); idle();
        expect_val("pre_r5", 32'h105);   read_src(5);
        expect_val("pre_pc", 32'h77);    read_src(20);
        expect_val("pre_zlow", 32'h13);  read_src(S_ZL);
        expect_val("pre_mar", 32'h66);   compare(mar);

        // Assert clear with every load active; registers must stay at zero.
        Read = 1; Mdatain = 32'hA5A5A5A5; MDRin = 1; Rin = '1; PCin = 1; Zin = 1; MARin = 1;
        Yin = 1; HIin = 1; LOin = 1; InPortout = 1; opcode = OP_ADD;
        #2 clear = 1'b0;
        #1;
        expect_val("reset_mar", 32'h0);
        compare(mar);
        for (int k = 0; k < 22; k++) begin
            expect_val($sformatf("reset_src%0d", k), 32'h0);
            read_src(k);
        end
        expect_val("reset_mar_late", 32'h0);
        compare(mar);
        idle();
        @(negedge Clock) clear = 1'b1;
        tick();
        Mdatain = 32'h30; InPortout = 1; opcode = OP_ADD; Zin = 1;
        tick(); idle();
        expect_val("reset_y", 32'h30); read_src(S_ZL);

        // Divide 0x12 by 0x14 through R6/R7.
        load(32'h12, 6);
        load(32'h14, 7);
        Rout[6] = 1; Yin = 1; tick(); idle();
        Rout[7] = 1; opcode = OP_DIV; Zin = 1; tick(); idle();
        expect_val("div_zhigh", 32'h12); read_src(S_ZH);
        expect_val("div_zlow", 32'h0);   read_src(S_ZL);
        Zlowout = 1; LOin = 1; tick(); idle();
        expect_val("div_lo", 32'h0);     read_src(D_LO);

        alu_op(OP_MUL, 32'hFFFFFFFE, 32'h3);
        expect_val("mul_zhigh", 32'hFFFFFFFF); read_src(S_ZH);
        expect_val("mul_zlow", 32'hFFFFFFFA);  read_src(S_ZL);
        Zhighout = 1; Zlowout = 1; HIin = 1; LOin = 1; tick(); idle();
        expect_val("zboth_hi", 32'hFFFFFFFF);  read_src(D_HI);
        expect_val("zboth_lo", 32'hFFFFFFFF);  read_src(D_LO);

        // IncPC overrides the opcode (Y still holds -2).
        load(32'h7, D_PC);
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; opcode = OP_MUL; tick(); idle();
        expect_val("inc_mar", 32'h7); compare(mar);
        expect_val("inc_zlow", 32'h8);  read_src(S_ZL);
        expect_val("inc_zhigh", 32'h0); read_src(S_ZH);
        load(32'hFFFFFFFF, D_PC);
        PCout = 1; IncPC = 1; Zin = 1; opcode = OP_MUL; tick(); idle();
        expect_val("inc_wrap_zlow", 32'h0);  read_src(S_ZL);
        expect_val("inc_wrap_zhigh", 32'h0); read_src(S_ZH);

        load(32'h5, D_Y);
        opcode = OP_DIV; Zin = 1; tick(); idle();
        expect_val("div0_zlow", 32'hFFFFFFFF); read_src(S_ZL);
        expect_val("div0_zhigh", 32'h5);       read_src(S_ZH);

        alu_op(OP_ROR, 32'h80000001, 32'h1);
        expect_val("ror", 32'hC0000000);  read_src(S_ZL);
        expect_val("ror_zhigh", 32'h0);   read_src(S_ZH);
        alu_op(OP_SHRA, 32'h80000001, 32'h1);
        expect_val("shra", 32'hC0000000); read_src(S_ZL);
        alu_op(OP_SHR, 32'h80000001, 32'h1);
        expect_val("shr", 32'h40000000);  read_src(S_ZL);
        alu_op(OP_SHL, 32'h80000001, 32'h1);
        expect_val("shl", 32'h00000002);  read_src(S_ZL);
        alu_op(OP_ROL, 32'h80000001, 32'h1);
        expect_val("rol", 32'h00000003);  read_src(S_ZL);
        alu_op(OP_ADD, 32'hFFFFFFFF, 32'h2);
        expect_val("add_wrap", 32'h1);    read_src(S_ZL);
        alu_op(OP_SUB, 32'h10, 32'h11);
        expect_val("sub", 32'hFFFFFFFF);  read_src(S_ZL);
        alu_op(OP_AND, 32'hF0F0, 32'hFF00);
        expect_val("and", 32'hF000);      read_src(S_ZL);
        alu_op(OP_OR, 32'hF0F0, 32'hFF00);
        expect_val("or", 32'hFFF0);       read_src(S_ZL);
        alu_op(OP_NEG, 32'h0, 32'h5);
        expect_val("neg", 32'hFFFFFFFB);  read_src(S_ZL);
        alu_op(5'b11111, 32'h7, 32'h9);
        expect_val("bad_op_zlow", 32'h0); read_src(S_ZL);
        expect_val("bad_op_zhigh", 32'h0); read_src(S_ZH);

        @(negedge Clock); #1;
        expect_val("bus_idle", 32'h0); compare(bus);
        opcode = OP_NOT; Zin = 1; tick(); idle();
        expect_val("not_idle_bus", 32'hFFFFFFFF); read_src(S_ZL);

        load(32'h22, 2);
        load(32'h99, 9);
        @(negedge Clock);
        Rout[2] = 1; Rout[9] = 1; HIout = 1; #1;
        expect_val("prio_r2_r9_hi", 32'h22); compare(bus);
        Rout = '0; PCout = 1; #1;
        expect_val("prio_hi_pc", 32'hFFFFFFFF); compare(bus);
        idle();

        Mdatain = 32'h11; InPortout = 1; Rin[4] = 1; tick();
        Mdatain = 32'h44; tick(); idle();
        expect_val("hold_enable_r4", 32'h44); read_src(4);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
